lsu_dmem_ctrl: RTL and testbench

Load/store initiator between the CPU MEM stage and the `dmem` data-memory port. It accepts one load or store request at a time through a valid/ready handshake and drives the `dmem` control signals: `W_en`, `R_en`, `addr`, `RW_type`, `din`, `pc`. Misaligned halfword and word accesses are split into a sequence of aligned `dmem` transactions, so `dmem` only ever sees accesses it handles correctly. Load results and store completion return to the pipeline as a one-cycle response pulse.

---
 rtl/lsu_dmem_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_lsu_dmem_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_ctrl.sv
// Load/store initiator for the dmem port. Misaligned halfword and word
// accesses are split into aligned dmem transactions.
//   state | meaning
//   IDLE  | waiting for a request
//   ACC   | first (or only) dmem access
//   LD_HI | upper word read of a split load
//   ST_B  | remaining byte writes of a split store
//   RESP  | one-cycle response pulse
module lsu_dmem_ctrl #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_W_en,
  output logic        mem_R_en,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_RW_type,
  output logic [31:0] mem_din,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_dout
);

  typedef enum logic [2:0] {IDLE, ACC, LD_HI, ST_B, RESP} state_t;

  state_t      state, state_n;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_q;
  logic        err_q;
  logic [1:0]  cnt_q;

  logic        accept;
  logic        illegal_in;
  logic        misal_in;
  logic        reject_in;
  logic        misal_q;
  logic        split_last;
  logic [31:0] ld_word;
  logic [31:0] rdata_n;
  logic [31:0] word_base;
  logic        w_raw;
  logic        r_raw;

  assign accept     = req_valid && req_ready;
  assign illegal_in = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
  assign misal_in   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign reject_in  = illegal_in || (misal_in && !SPLIT_EN);

  assign misal_q    = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                      ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
  assign split_last = (f3_q[1:0] == 2'b01) ? (cnt_q == 2'd1) : (cnt_q == 2'd3);
  assign word_base  = {addr_q[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, RESP: begin
        if (accept) state_n = reject_in ? RESP : ACC;
        else        state_n = IDLE;
      end
      ACC: begin
        if (!misal_q)  state_n = RESP;
        else if (we_q) state_n = ST_B;
        else           state_n = LD_HI;
      end
      LD_HI:   state_n = RESP;
      ST_B:    state_n = split_last ? RESP : ST_B;
      default: state_n = IDLE;
    endcase
  end

  // {hi,lo} >> 8*addr[1:0], with hi arriving on mem_dout during LD_HI
  always_comb begin
    case (addr_q[1:0])
      2'b01:   ld_word = {mem_dout[7:0],  lo_q[31:8]};
      2'b10:   ld_word = {mem_dout[15:0], lo_q[31:16]};
      2'b11:   ld_word = {mem_dout[23:0], lo_q[31:24]};
      default: ld_word = lo_q;
    endcase
  end

  always_comb begin
    rdata_n = 32'd0;
    if (state == ACC && !we_q && !misal_q) begin
      rdata_n = mem_dout;
    end else if (state == LD_HI) begin
      if (f3_q[1:0] == 2'b01)
        rdata_n = f3_q[2] ? {16'd0, ld_word[15:0]} : {{16{ld_word[15]}}, ld_word[15:0]};
      else
        rdata_n = ld_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      f3_q       <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      lo_q       <= 32'd0;
      err_q      <= 1'b0;
      cnt_q      <= 2'd0;
      mem_pc     <= 32'd0;
      resp_rdata <= 32'd0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        mem_pc  <= req_pc;
        err_q   <= reject_in;
        cnt_q   <= 2'd0;
      end else if (state == ACC || state == ST_B) begin
        cnt_q <= cnt_q + 2'd1;
      end
      if (state == ACC) lo_q <= mem_dout;
      if (state_n == RESP) resp_rdata <= rdata_n;
    end
  end

  always_comb begin
    w_raw       = 1'b0;
    r_raw       = 1'b0;
    mem_addr    = 32'd0;
    mem_RW_type = 3'd0;
    mem_din     = 32'd0;
    case (state)
      ACC: begin
        if (!misal_q) begin
          mem_addr    = addr_q;
          mem_RW_type = f3_q;
          mem_din     = wdata_q;
          w_raw       = we_q;
          r_raw       = !we_q;
        end else if (we_q) begin
          mem_addr = addr_q + {30'd0, cnt_q};
          mem_din  = {24'd0, 8'(wdata_q >> {cnt_q, 3'b000})};
          w_raw    = 1'b1;
        end else begin
          mem_addr    = word_base;
          mem_RW_type = 3'b010;
          r_raw       = 1'b1;
        end
      end
      LD_HI: begin
        mem_addr    = word_base + 32'd4;
        mem_RW_type = 3'b010;
        r_raw       = 1'b1;
      end
      ST_B: begin
        mem_addr = addr_q + {30'd0, cnt_q};
        mem_din  = {24'd0, 8'(wdata_q >> {cnt_q, 3'b000})};
        w_raw    = 1'b1;
      end
      default: ;
    endcase
    // no dmem write or read may happen in a reset cycle
    mem_W_en   = w_raw && !rst;
    mem_R_en   = r_raw && !rst;
    req_ready  = (state == IDLE || state == RESP) && !rst;
    resp_valid = (state == RESP);
    resp_err   = (state == RESP) && err_q;
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Directed bench for lsu_dmem_ctrl with a byte-array dmem model and a
// second instance built with splitting disabled.
module tb_lsu_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_valid_ns, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        req_ready, resp_valid, resp_err, mem_W_en, mem_R_en;
  logic [31:0] resp_rdata, mem_addr, mem_din, mem_pc, mem_dout;
  logic [2:0]  mem_RW_type;
  logic        ns_req_ready, ns_resp_valid, ns_resp_err, ns_W_en, ns_R_en;
  logic [31:0] ns_resp_rdata, ns_addr, ns_din, ns_pc;
  logic [2:0]  ns_RW_type;

  lsu_dmem_ctrl #(.SPLIT_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_W_en(mem_W_en),
    .mem_R_en(mem_R_en), .mem_addr(mem_addr), .mem_RW_type(mem_RW_type),
    .mem_din(mem_din), .mem_pc(mem_pc), .mem_dout(mem_dout));

  lsu_dmem_ctrl #(.SPLIT_EN(1'b0)) u_ns (
    .clk(clk), .rst(rst), .req_valid(req_valid_ns), .req_ready(ns_req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc), .resp_valid(ns_resp_valid),
    .resp_rdata(ns_resp_rdata), .resp_err(ns_resp_err), .mem_W_en(ns_W_en),
    .mem_R_en(ns_R_en), .mem_addr(ns_addr), .mem_RW_type(ns_RW_type),
    .mem_din(ns_din), .mem_pc(ns_pc), .mem_dout(32'd0));

  // dmem model: 4 KiB byte array, combinational read with extension
  logic [7:0]  dm [0:4095];
  logic [11:0] ra;
  assign ra = mem_addr[11:0];

  always_comb begin
    case (mem_RW_type)
      3'b000:  mem_dout = {{24{dm[ra][7]}}, dm[ra]};
      3'b100:  mem_dout = {24'd0, dm[ra]};
      3'b001:  mem_dout = {{16{dm[ra+12'd1][7]}}, dm[ra+12'd1], dm[ra]};
      3'b101:  mem_dout = {16'd0, dm[ra+12'd1], dm[ra]};
      default: mem_dout = {dm[ra+12'd3], dm[ra+12'd2], dm[ra+12'd1], dm[ra]};
    endcase
  end

  logic        mem_clr, log_clr, pl_en;
  logic [11:0] pl_addr;
  logic [7:0]  pl_data;
  int          wr_cnt, rd_cnt, ns_en_cnt;
  logic [31:0] wr_addr [0:7];
  logic [31:0] wr_din  [0:7];
  logic [2:0]  wr_type [0:7];
  logic [31:0] rd_addr [0:7];

  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 4096; i++) dm[i] <= 8'h00;
    if (pl_en) dm[pl_addr] <= pl_data;
    if (mem_W_en) begin
      case (mem_RW_type)
        3'b000: dm[ra] <= mem_din[7:0];
        3'b001: begin dm[ra] <= mem_din[7:0]; dm[ra+12'd1] <= mem_din[15:8]; end
        default: begin
          dm[ra]       <= mem_din[7:0];
          dm[ra+12'd1] <= mem_din[15:8];
          dm[ra+12'd2] <= mem_din[23:16];
          dm[ra+12'd3] <= mem_din[31:24];
        end
      endcase
    end
    if (log_clr) begin
      wr_cnt <= 0;
      rd_cnt <= 0;
    end else begin
      if (mem_W_en) begin
        wr_addr[wr_cnt[2:0]] <= mem_addr;
        wr_din[wr_cnt[2:0]]  <= mem_din;
        wr_type[wr_cnt[2:0]] <= mem_RW_type;
        wr_cnt <= wr_cnt + 1;
      end
      if (mem_R_en) begin
        rd_addr[rd_cnt[2:0]] <= mem_addr;
        rd_cnt <= rd_cnt + 1;
      end
    end
    if (ns_W_en || ns_R_en) ns_en_cnt <= ns_en_cnt + 1;
  end

  int errors = 0;
  int checks = 0;
  int lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // called at a negedge; returns #1 after the accept edge
  task automatic start_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] pc);
    int g;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_pc = pc;
    req_valid = 1'b1; log_clr = 1'b1;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    req_valid = 1'b0; log_clr = 1'b0;
  endtask

  // counts accept-relative edges until resp_valid, sampled at negedges
  task automatic wait_resp(output int l);
    l = 0;
    do begin @(negedge clk); l++; end while (!resp_valid && l < 20);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_b [0:3];

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_valid_ns = 1'b0; req_we = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; req_pc = 32'd0;
    mem_clr = 1'b1; log_clr = 1'b1; pl_en = 1'b0; pl_addr = 12'd0; pl_data = 8'd0;

    @(negedge clk);
    mem_clr = 1'b0;
    check("rst_ready",   {31'd0, req_ready},  32'd0);
    check("rst_rvalid",  {31'd0, resp_valid}, 32'd0);
    check("rst_wen",     {31'd0, mem_W_en},   32'd0);
    check("rst_addr",    mem_addr,            32'd0);
    check("rst_pc",      mem_pc,              32'd0);
    check("rst_rdata",   resp_rdata,          32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // aligned word store then load
    start_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h1000);
    wait_resp(lat);
    check("sw_lat",    32'(lat),          32'd2);
    check("sw_err",    {31'd0, resp_err}, 32'd0);
    check("sw_rdata",  resp_rdata,        32'd0);
    check("sw_nwr",    32'(wr_cnt),       32'd1);
    check("sw_waddr",  wr_addr[0],        32'h100);
    check("sw_wdin",   wr_din[0],         32'hDEADBEEF);
    check("sw_wtype",  {29'd0, wr_type[0]}, 32'd2);
    check("sw_pc",     mem_pc,            32'h1000);
    check("resp_addr0", mem_addr,         32'd0);
    start_req(1'b0, 3'b010, 32'h100, 32'd0, 32'h1004);
    wait_resp(lat);
    check("lw_lat",    32'(lat),          32'd2);
    check("lw_rdata",  resp_rdata,        32'hDEADBEEF);
    check("lw_nrd",    32'(rd_cnt),       32'd1);
    check("lw_raddr",  rd_addr[0],        32'h100);

    // misaligned word store, then aligned load over the written bytes
    start_req(1'b1, 3'b010, 32'h103, 32'h11223344, 32'h1008);
    wait_resp(lat);
    check("msw_lat",   32'(lat),          32'd5);
    check("msw_nwr",   32'(wr_cnt),       32'd4);
    exp_b[0] = 8'h44; exp_b[1] = 8'h33; exp_b[2] = 8'h22; exp_b[3] = 8'h11;
    for (int k = 0; k < 4; k++) begin
      check("msw_waddr", wr_addr[k], 32'h103 + 32'(k));
      check("msw_wdin",  wr_din[k],  {24'd0, exp_b[k]});
      check("msw_wtype", {29'd0, wr_type[k]}, 32'd0);
    end
    start_req(1'b0, 3'b010, 32'h104, 32'd0, 32'h100C);
    wait_resp(lat);
    check("lw104_rdata", resp_rdata, 32'h00112233);

    // misaligned halfword loads, signed and unsigned
    preload(12'h1FF, 8'h80);
    preload(12'h200, 8'hFF);
    start_req(1'b0, 3'b001, 32'h1FF, 32'd0, 32'h1010);
    wait_resp(lat);
    check("lh_lat",    32'(lat),   32'd3);
    check("lh_nrd",    32'(rd_cnt), 32'd2);
    check("lh_raddr0", rd_addr[0], 32'h1FC);
    check("lh_raddr1", rd_addr[1], 32'h200);
    check("lh_rdata",  resp_rdata, 32'hFFFFFF80);
    start_req(1'b0, 3'b101, 32'h1FF, 32'd0, 32'h1014);
    wait_resp(lat);
    check("lhu_rdata", resp_rdata, 32'h0000FF80);
    start_req(1'b0, 3'b000, 32'h1FF, 32'd0, 32'h1018);
    wait_resp(lat);
    check("lb_lat",    32'(lat),   32'd2);
    check("lb_rdata",  resp_rdata, 32'hFFFFFF80);

    // illegal funct3
    start_req(1'b0, 3'b011, 32'h100, 32'd0, 32'h101C);
    wait_resp(lat);
    check("ill_lat",   32'(lat),          32'd1);
    check("ill_err",   {31'd0, resp_err}, 32'd1);
    check("ill_nrd",   32'(rd_cnt),       32'd0);
    start_req(1'b1, 3'b110, 32'h100, 32'h12345678, 32'h1020);
    wait_resp(lat);
    check("ill_st_err", {31'd0, resp_err}, 32'd1);
    check("ill_st_nwr", 32'(wr_cnt),       32'd0);

    // splitting disabled: misaligned word load is rejected
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h2; req_pc = 32'h2000;
    req_valid_ns = 1'b1;
    check("ns_ready", {31'd0, ns_req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid_ns = 1'b0;
    @(negedge clk);
    check("ns_rvalid", {31'd0, ns_resp_valid}, 32'd1);
    check("ns_err",    {31'd0, ns_resp_err},   32'd1);
    check("ns_noacc",  32'(ns_en_cnt),         32'd0);

    // misaligned halfword store
    start_req(1'b1, 3'b001, 32'h201, 32'h0000ABCD, 32'h1024);
    wait_resp(lat);
    check("msh_lat",   32'(lat),    32'd3);
    check("msh_nwr",   32'(wr_cnt), 32'd2);
    check("msh_waddr1", wr_addr[1], 32'h202);
    check("msh_wdin1",  wr_din[1],  32'h000000AB);

    // reset during byte 2 of a split word store
    start_req(1'b1, 3'b010, 32'h301, 32'h55667788, 32'h1028);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_wen",   {31'd0, mem_W_en},  32'd0);
    check("rst_mid_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready_after", {31'd0, req_ready}, 32'd1);
    check("rst_mid_nwr",  32'(wr_cnt),          32'd2);
    check("rst_mid_b0",   {24'd0, dm[12'h301]}, 32'h88);
    check("rst_mid_b1",   {24'd0, dm[12'h302]}, 32'h77);
    check("rst_mid_b2",   {24'd0, dm[12'h303]}, 32'h00);

    // back-to-back: second request accepted in the RESP cycle
    start_req(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h102C);
    wait_resp(lat);
    check("b2b_st_lat", 32'(lat), 32'd2);
    start_req(1'b0, 3'b010, 32'h400, 32'd0, 32'h1030);
    @(negedge clk);
    check("b2b_ren",  {31'd0, mem_R_en}, 32'd1);
    check("b2b_addr", mem_addr,          32'h400);
    check("b2b_pc",   mem_pc,            32'h1030);
    wait_resp(lat);
    check("b2b_lat",   32'(lat),   32'd1);
    check("b2b_rdata", resp_rdata, 32'hCAFEF00D);

    // wrap-around of the upper word address
    preload(12'hFFE, 8'h34);
    preload(12'hFFF, 8'h12);
    preload(12'h000, 8'h78);
    preload(12'h001, 8'h56);
    start_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, 32'h1034);
    wait_resp(lat);
    check("wrap_lat",    32'(lat),   32'd3);
    check("wrap_raddr0", rd_addr[0], 32'hFFFFFFFC);
    check("wrap_raddr1", rd_addr[1], 32'h00000000);
    check("wrap_rdata",  resp_rdata, 32'h56781234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
